// File: rtl/cacheline_mem_arbiter_if.sv
// Cache-side line ports and the shared 64-bit burst memory port, bundled for the arbiter.
// Arbiter uses the master view; caches and memory model use the slave view.
interface cacheline_mem_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int LINE_BITS  = 256,
    parameter int BEAT_BITS  = 64
);
    logic [ADDR_WIDTH-1:0] i_dfp_addr;
    logic                  i_dfp_read;
    logic [LINE_BITS-1:0]  i_dfp_rdata;
    logic                  i_dfp_resp;

    logic [ADDR_WIDTH-1:0] d_dfp_addr;
    logic                  d_dfp_read;
    logic                  d_dfp_write;
    logic [LINE_BITS-1:0]  d_dfp_wdata;
    logic [LINE_BITS-1:0]  d_dfp_rdata;
    logic                  d_dfp_resp;

    logic [ADDR_WIDTH-1:0] bmem_addr;
    logic                  bmem_read;
    logic                  bmem_write;
    logic [BEAT_BITS-1:0]  bmem_wdata;
    logic                  bmem_ready;
    logic [ADDR_WIDTH-1:0] bmem_raddr;
    logic [BEAT_BITS-1:0]  bmem_rdata;
    logic                  bmem_rvalid;

    modport master (
        input  i_dfp_addr, i_dfp_read,
        output i_dfp_rdata, i_dfp_resp,
        input  d_dfp_addr, d_dfp_read, d_dfp_write, d_dfp_wdata,
        output d_dfp_rdata, d_dfp_resp,
        output bmem_addr, bmem_read, bmem_write, bmem_wdata,
        input  bmem_ready, bmem_raddr, bmem_rdata, bmem_rvalid
    );

    modport slave (
        output i_dfp_addr, i_dfp_read,
        input  i_dfp_rdata, i_dfp_resp,
        output d_dfp_addr, d_dfp_read, d_dfp_write, d_dfp_wdata,
        input  d_dfp_rdata, d_dfp_resp,
        input  bmem_addr, bmem_read, bmem_write, bmem_wdata,
        output bmem_ready, bmem_raddr, bmem_rdata, bmem_rvalid
    );
endinterface

// File: rtl/cacheline_mem_arbiter.sv
// Round-robin arbiter serialising I/D cacheline fills and writebacks onto one 64-bit burst port.
// One line in flight; read = grant + request (stalls on bmem_ready) + 4 beats + 1 resp cycle.
module cacheline_mem_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int LINE_BITS  = 256,
    parameter int BEAT_BITS  = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    cacheline_mem_arbiter_if.master bus
);
    localparam int BEATS  = LINE_BITS / BEAT_BITS;
    localparam int BEAT_W = $clog2(BEATS);
    localparam logic [ADDR_WIDTH-1:0] OFF_MASK = ADDR_WIDTH'(LINE_BITS / 8 - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_REQ,
        S_RD_DATA,
        S_WR_BURST,
        S_RESP
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic [BEAT_W-1:0]     r_beat;
    logic                  r_last_grant;   // 1: D was granted last, 0: I was
    logic                  r_gnt_d;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [LINE_BITS-1:0]  r_wdata;
    logic [LINE_BITS-1:0]  r_line;
    logic [LINE_BITS-1:0]  r_i_rdata;
    logic [LINE_BITS-1:0]  r_d_rdata;

    logic                  w_req_i;
    logic                  w_req_d;
    logic                  w_pick_d;
    logic                  w_grant;
    logic                  w_beat_ok;
    logic                  w_last;
    logic [BEAT_BITS-1:0]  w_wbeat;
    logic [LINE_BITS-1:0]  w_line_upd;

    logic [ADDR_WIDTH-1:0] w_bmem_addr;
    logic                  w_bmem_read;
    logic                  w_bmem_write;
    logic [BEAT_BITS-1:0]  w_bmem_wdata;
    logic                  w_i_resp;
    logic                  w_d_resp;

    assign w_req_i   = bus.i_dfp_read;
    assign w_req_d   = bus.d_dfp_read | bus.d_dfp_write;
    assign w_pick_d  = w_req_d & (~w_req_i | ~r_last_grant);
    assign w_grant   = w_req_i | w_req_d;
    assign w_beat_ok = bus.bmem_rvalid && (bus.bmem_raddr == r_addr);
    assign w_last    = (r_beat == BEAT_W'(BEATS - 1));

    always_comb begin
        w_wbeat    = '0;
        w_line_upd = r_line;
        for (int k = 0; k < BEATS; k++) begin
            if (r_beat == BEAT_W'(k)) begin
                w_wbeat                                 = r_wdata[k*BEAT_BITS +: BEAT_BITS];
                w_line_upd[k*BEAT_BITS +: BEAT_BITS]    = bus.bmem_rdata;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_grant) begin
                    w_next = (w_pick_d && bus.d_dfp_write) ? S_WR_BURST : S_RD_REQ;
                end
            end
            S_RD_REQ: begin
                if (bus.bmem_ready) w_next = S_RD_DATA;
            end
            S_RD_DATA: begin
                if (w_beat_ok && w_last) w_next = S_RESP;
            end
            S_WR_BURST: begin
                if (bus.bmem_ready && w_last) w_next = S_RESP;
            end
            S_RESP: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_comb begin
        w_bmem_addr  = '0;
        w_bmem_read  = 1'b0;
        w_bmem_write = 1'b0;
        w_bmem_wdata = '0;
        w_i_resp     = 1'b0;
        w_d_resp     = 1'b0;
        case (r_state)
            S_RD_REQ: begin
                w_bmem_read = 1'b1;
                w_bmem_addr = r_addr;
            end
            S_WR_BURST: begin
                w_bmem_write = 1'b1;
                w_bmem_addr  = r_addr;
                w_bmem_wdata = w_wbeat;
            end
            S_RESP: begin
                w_i_resp = ~r_gnt_d;
                w_d_resp = r_gnt_d;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_beat       <= '0;
            r_last_grant <= 1'b0;
            r_gnt_d      <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_line       <= '0;
            r_i_rdata    <= '0;
            r_d_rdata    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_grant) begin
                        r_gnt_d      <= w_pick_d;
                        r_last_grant <= w_pick_d;
                        r_beat       <= '0;
                        r_addr       <= (w_pick_d ? bus.d_dfp_addr : bus.i_dfp_addr) & ~OFF_MASK;
                        if (w_pick_d) r_wdata <= bus.d_dfp_wdata;
                    end
                end
                S_RD_DATA: begin
                    // Beats tagged with another base address belong to someone else; drop them.
                    if (w_beat_ok) begin
                        r_line <= w_line_upd;
                        if (w_last) begin
                            r_beat <= '0;
                            if (r_gnt_d) r_d_rdata <= w_line_upd;
                            else         r_i_rdata <= w_line_upd;
                        end else begin
                            r_beat <= r_beat + 1'b1;
                        end
                    end
                end
                S_WR_BURST: begin
                    if (bus.bmem_ready) begin
                        r_beat <= w_last ? '0 : r_beat + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.bmem_addr   = w_bmem_addr;
    assign bus.bmem_read   = w_bmem_read;
    assign bus.bmem_write  = w_bmem_write;
    assign bus.bmem_wdata  = w_bmem_wdata;
    assign bus.i_dfp_resp  = w_i_resp;
    assign bus.d_dfp_resp  = w_d_resp;
    assign bus.i_dfp_rdata = r_i_rdata;
    assign bus.d_dfp_rdata = r_d_rdata;
endmodule

// File: tb/tb_cacheline_mem_arbiter.sv
// Directed bench for the cacheline memory arbiter: reset, reads, stalled writes, arbitration, stray beats, mid-burst reset.
module tb_cacheline_mem_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    localparam logic [63:0] B1 = 64'h1111_1111_1111_1111;
    localparam logic [63:0] B2 = 64'h2222_2222_2222_2222;
    localparam logic [63:0] B3 = 64'h3333_3333_3333_3333;
    localparam logic [63:0] B4 = 64'h4444_4444_4444_4444;

    always #5 clk = ~clk;

    cacheline_mem_arbiter_if bus ();

    cacheline_mem_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic idle_inputs();
        bus.i_dfp_addr  = '0;
        bus.i_dfp_read  = 1'b0;
        bus.d_dfp_addr  = '0;
        bus.d_dfp_read  = 1'b0;
        bus.d_dfp_write = 1'b0;
        bus.d_dfp_wdata = '0;
        bus.bmem_ready  = 1'b0;
        bus.bmem_raddr  = '0;
        bus.bmem_rdata  = '0;
        bus.bmem_rvalid = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b0;
        bus.bmem_rvalid = 1'b1;
        bus.bmem_ready  = 1'b1;
        step();
        step();
        n_tests++; if (bus.bmem_read !== 1'b0) begin n_fail++; $display("FAIL reset_bmem_read got=%b exp=0", bus.bmem_read); end
        n_tests++; if (bus.bmem_write !== 1'b0) begin n_fail++; $display("FAIL reset_bmem_write got=%b exp=0", bus.bmem_write); end
        n_tests++; if (bus.bmem_addr !== 32'h0) begin n_fail++; $display("FAIL reset_bmem_addr got=%h exp=0", bus.bmem_addr); end
        n_tests++; if (bus.bmem_wdata !== 64'h0) begin n_fail++; $display("FAIL reset_bmem_wdata got=%h exp=0", bus.bmem_wdata); end
        n_tests++; if (bus.i_dfp_resp !== 1'b0 || bus.d_dfp_resp !== 1'b0) begin n_fail++; $display("FAIL reset_resp got=%b%b exp=00", bus.i_dfp_resp, bus.d_dfp_resp); end
        n_tests++; if (bus.i_dfp_rdata !== 256'h0 || bus.d_dfp_rdata !== 256'h0) begin n_fail++; $display("FAIL reset_rdata got_i=%h got_d=%h exp=0", bus.i_dfp_rdata, bus.d_dfp_rdata); end
        idle_inputs();
        rst = 1'b1;
        step();
    endtask

    task automatic test_i_read();
        logic [63:0] bt[4];
        int pend = 0;
        int resp_cyc = -1;
        int i_cnt = 0;
        int d_cnt = 0;
        int req_seen = 0;
        bt[0] = B1; bt[1] = B2; bt[2] = B3; bt[3] = B4;
        bus.i_dfp_addr = 32'h0000_1234;
        bus.i_dfp_read = 1'b1;
        bus.bmem_ready = 1'b1;
        bus.bmem_raddr = 32'h0000_1220;
        for (int c = 1; c <= 12; c++) begin
            step();
            if (bus.bmem_read) begin
                req_seen++;
                n_tests++; if (bus.bmem_addr !== 32'h0000_1220) begin n_fail++; $display("FAIL iread_bmem_addr got=%h exp=00001220", bus.bmem_addr); end
            end
            if (bus.i_dfp_resp) begin
                if (i_cnt == 0) resp_cyc = c;
                i_cnt++;
                bus.i_dfp_read = 1'b0;
            end
            if (bus.d_dfp_resp) d_cnt++;
            if (pend > 0) begin
                bus.bmem_rvalid = 1'b1;
                bus.bmem_rdata  = bt[4-pend];
                pend--;
            end else begin
                bus.bmem_rvalid = 1'b0;
            end
            if (bus.bmem_read) pend = 4;
        end
        bus.bmem_ready = 1'b0;
        n_tests++; if (req_seen != 1) begin n_fail++; $display("FAIL iread_req_cycles got=%0d exp=1", req_seen); end
        n_tests++; if (resp_cyc != 6) begin n_fail++; $display("FAIL iread_latency got=%0d exp=6 edges after request", resp_cyc); end
        n_tests++; if (i_cnt != 1) begin n_fail++; $display("FAIL iread_resp_count got=%0d exp=1", i_cnt); end
        n_tests++; if (d_cnt != 0) begin n_fail++; $display("FAIL iread_d_resp got=%0d exp=0", d_cnt); end
        n_tests++; if (bus.i_dfp_rdata !== {B4, B3, B2, B1}) begin n_fail++; $display("FAIL iread_rdata got=%h exp=%h", bus.i_dfp_rdata, {B4, B3, B2, B1}); end
    endtask

    task automatic test_d_write();
        logic [63:0] bt[4];
        logic        pat[6];
        int idx = 0;
        int acc = 0;
        int rd_bad = 0;
        int d_cnt = 0;
        bt[0] = B1; bt[1] = B2; bt[2] = B3; bt[3] = B4;
        pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b1; pat[3] = 1'b1; pat[4] = 1'b0; pat[5] = 1'b1;
        bus.d_dfp_addr  = 32'h0000_8000;
        bus.d_dfp_wdata = {B4, B3, B2, B1};
        bus.d_dfp_write = 1'b1;
        for (int c = 1; c <= 14; c++) begin
            step();
            if (bus.bmem_read) rd_bad++;
            if (bus.bmem_write && idx < 6 && acc < 4) begin
                n_tests++; if (bus.bmem_wdata !== bt[acc] || bus.bmem_addr !== 32'h0000_8000) begin n_fail++; $display("FAIL dwrite_beat%0d got=%h@%h exp=%h@00008000", acc, bus.bmem_wdata, bus.bmem_addr, bt[acc]); end
                bus.bmem_ready = pat[idx];
                if (pat[idx]) acc++;
                idx++;
            end else begin
                if (bus.bmem_write) idx++;
                bus.bmem_ready = 1'b0;
            end
            if (bus.d_dfp_resp) begin
                d_cnt++;
                bus.d_dfp_write = 1'b0;
            end
        end
        n_tests++; if (acc != 4 || idx != 6) begin n_fail++; $display("FAIL dwrite_beats got=%0d accepted/%0d cycles exp=4/6", acc, idx); end
        n_tests++; if (rd_bad != 0) begin n_fail++; $display("FAIL dwrite_no_read got=%0d exp=0", rd_bad); end
        n_tests++; if (d_cnt != 1) begin n_fail++; $display("FAIL dwrite_resp_count got=%0d exp=1", d_cnt); end
        n_tests++; if (bus.d_dfp_rdata !== 256'h0) begin n_fail++; $display("FAIL dwrite_rdata_kept got=%h exp=0", bus.d_dfp_rdata); end
    endtask

    task automatic test_both_read();
        logic [31:0]  cur_addr = '0;
        logic [31:0]  first_addr = '0;
        logic [255:0] exp_i;
        logic [255:0] exp_d;
        int pend = 0;
        int n_req = 0;
        int first_resp = 0;
        int i_cnt = 0;
        int d_cnt = 0;
        for (int k = 0; k < 4; k++) begin
            exp_i[k*64 +: 64] = {32'h0000_2040, 32'(k)};
            exp_d[k*64 +: 64] = {32'h0000_4080, 32'(k)};
        end
        rst = 1'b0;
        idle_inputs();
        step();
        rst = 1'b1;
        step();
        bus.i_dfp_addr = 32'h0000_2040;
        bus.d_dfp_addr = 32'h0000_4080;
        bus.i_dfp_read = 1'b1;
        bus.d_dfp_read = 1'b1;
        bus.bmem_ready = 1'b1;
        for (int c = 1; c <= 30; c++) begin
            step();
            if (bus.d_dfp_resp) begin
                d_cnt++;
                if (first_resp == 0) first_resp = 1;
                bus.d_dfp_read = 1'b0;
            end
            if (bus.i_dfp_resp) begin
                i_cnt++;
                if (first_resp == 0) first_resp = 2;
                bus.i_dfp_read = 1'b0;
            end
            if (pend > 0) begin
                bus.bmem_rvalid = 1'b1;
                bus.bmem_raddr  = cur_addr;
                bus.bmem_rdata  = {cur_addr, 32'(4 - pend)};
                pend--;
            end else begin
                bus.bmem_rvalid = 1'b0;
            end
            if (bus.bmem_read) begin
                if (n_req == 0) first_addr = bus.bmem_addr;
                n_req++;
                cur_addr = bus.bmem_addr;
                pend = 4;
            end
        end
        bus.bmem_ready = 1'b0;
        n_tests++; if (first_addr !== 32'h0000_4080) begin n_fail++; $display("FAIL both_first_grant got=%h exp=00004080", first_addr); end
        n_tests++; if (n_req != 2) begin n_fail++; $display("FAIL both_req_count got=%0d exp=2", n_req); end
        n_tests++; if (first_resp != 1) begin n_fail++; $display("FAIL both_resp_order got=%0d exp=1 (D first)", first_resp); end
        n_tests++; if (d_cnt != 1 || i_cnt != 1) begin n_fail++; $display("FAIL both_resp_count got=d%0d/i%0d exp=d1/i1", d_cnt, i_cnt); end
        n_tests++; if (bus.d_dfp_rdata !== exp_d) begin n_fail++; $display("FAIL both_d_rdata got=%h exp=%h", bus.d_dfp_rdata, exp_d); end
        n_tests++; if (bus.i_dfp_rdata !== exp_i) begin n_fail++; $display("FAIL both_i_rdata got=%h exp=%h", bus.i_dfp_rdata, exp_i); end
    endtask

    task automatic test_stray();
        logic [31:0]  ra[5];
        logic [63:0]  rd[5];
        logic [255:0] i_before;
        int pend = 0;
        int resp_cyc = -1;
        int d_cnt = 0;
        ra[0] = 32'h0000_3000; rd[0] = 64'hC1C1_0000_0000_0001;
        ra[1] = 32'h0000_3000; rd[1] = 64'hC2C2_0000_0000_0002;
        ra[2] = 32'h0000_FFE0; rd[2] = 64'hDEAD_BEEF_DEAD_BEEF;
        ra[3] = 32'h0000_3000; rd[3] = 64'hC3C3_0000_0000_0003;
        ra[4] = 32'h0000_3000; rd[4] = 64'hC4C4_0000_0000_0004;
        i_before = bus.i_dfp_rdata;
        bus.d_dfp_addr = 32'h0000_301C;
        bus.d_dfp_read = 1'b1;
        bus.bmem_ready = 1'b1;
        for (int c = 1; c <= 14; c++) begin
            step();
            if (bus.d_dfp_resp) begin
                if (d_cnt == 0) resp_cyc = c;
                d_cnt++;
                bus.d_dfp_read = 1'b0;
            end
            if (pend > 0) begin
                bus.bmem_rvalid = 1'b1;
                bus.bmem_raddr  = ra[5-pend];
                bus.bmem_rdata  = rd[5-pend];
                pend--;
            end else begin
                bus.bmem_rvalid = 1'b0;
            end
            if (bus.bmem_read) begin
                n_tests++; if (bus.bmem_addr !== 32'h0000_3000) begin n_fail++; $display("FAIL stray_bmem_addr got=%h exp=00003000", bus.bmem_addr); end
                pend = 5;
            end
        end
        bus.bmem_ready = 1'b0;
        n_tests++; if (bus.d_dfp_rdata !== {rd[4], rd[3], rd[1], rd[0]}) begin n_fail++; $display("FAIL stray_rdata got=%h exp=%h", bus.d_dfp_rdata, {rd[4], rd[3], rd[1], rd[0]}); end
        n_tests++; if (d_cnt != 1 || resp_cyc != 7) begin n_fail++; $display("FAIL stray_resp got=%0d@%0d exp=1@7", d_cnt, resp_cyc); end
        n_tests++; if (bus.i_dfp_rdata !== i_before) begin n_fail++; $display("FAIL stray_i_rdata_kept got=%h exp=%h", bus.i_dfp_rdata, i_before); end
    endtask

    task automatic test_rw_reset();
        logic [63:0] bt[4];
        int acc = 0;
        int rd_bad = 0;
        int first_chk = 0;
        int d_cnt = 0;
        bt[0] = 64'hE1E1_E1E1_E1E1_E1E1;
        bt[1] = 64'hE2E2_E2E2_E2E2_E2E2;
        bt[2] = 64'hE3E3_E3E3_E3E3_E3E3;
        bt[3] = 64'hE4E4_E4E4_E4E4_E4E4;
        bus.d_dfp_addr  = 32'h0000_9000;
        bus.d_dfp_wdata = {bt[3], bt[2], bt[1], bt[0]};
        bus.d_dfp_read  = 1'b1;
        bus.d_dfp_write = 1'b1;
        bus.bmem_ready  = 1'b1;
        for (int c = 1; c <= 10 && acc < 2; c++) begin
            step();
            if (bus.bmem_read) rd_bad++;
            if (bus.bmem_write) begin
                n_tests++; if (bus.bmem_wdata !== bt[acc]) begin n_fail++; $display("FAIL rw_beat%0d got=%h exp=%h", acc, bus.bmem_wdata, bt[acc]); end
                acc++;
            end
        end
        step();
        n_tests++; if (acc != 2 || bus.bmem_write !== 1'b1 || rd_bad != 0) begin n_fail++; $display("FAIL rw_write_burst got=acc%0d/wr%b/rd%0d exp=acc2/wr1/rd0", acc, bus.bmem_write, rd_bad); end
        #2;
        rst = 1'b0;
        #1;
        n_tests++; if (bus.bmem_write !== 1'b0 || bus.bmem_read !== 1'b0 || bus.bmem_addr !== 32'h0 || bus.bmem_wdata !== 64'h0) begin n_fail++; $display("FAIL rw_reset_bmem got=wr%b rd%b a=%h d=%h exp=all0", bus.bmem_write, bus.bmem_read, bus.bmem_addr, bus.bmem_wdata); end
        n_tests++; if (bus.i_dfp_rdata !== 256'h0 || bus.d_dfp_rdata !== 256'h0 || bus.i_dfp_resp !== 1'b0 || bus.d_dfp_resp !== 1'b0) begin n_fail++; $display("FAIL rw_reset_dfp got_i=%h got_d=%h exp=0", bus.i_dfp_rdata, bus.d_dfp_rdata); end
        bus.d_dfp_read  = 1'b0;
        bus.d_dfp_write = 1'b0;
        bus.bmem_rvalid = 1'b1;
        bus.bmem_raddr  = 32'h0000_9000;
        bus.bmem_rdata  = 64'hBAD0_BAD0_BAD0_BAD0;
        #2;
        rst = 1'b1;
        step();
        bus.bmem_rvalid = 1'b0;
        bus.d_dfp_write = 1'b1;
        acc = 0;
        for (int c = 1; c <= 12; c++) begin
            step();
            if (bus.bmem_read) rd_bad++;
            if (bus.bmem_write) begin
                if (first_chk == 0) begin
                    first_chk = 1;
                    n_tests++; if (bus.bmem_wdata !== bt[0] || bus.bmem_addr !== 32'h0000_9000) begin n_fail++; $display("FAIL rw_restart_beat0 got=%h@%h exp=%h@00009000", bus.bmem_wdata, bus.bmem_addr, bt[0]); end
                end
                acc++;
            end
            if (bus.d_dfp_resp) begin
                d_cnt++;
                bus.d_dfp_write = 1'b0;
            end
        end
        n_tests++; if (acc != 4 || d_cnt != 1 || rd_bad != 0) begin n_fail++; $display("FAIL rw_restart_burst got=beats%0d/resp%0d/rd%0d exp=4/1/0", acc, d_cnt, rd_bad); end
        n_tests++; if (bus.d_dfp_rdata !== 256'h0) begin n_fail++; $display("FAIL rw_stray_after_reset got=%h exp=0", bus.d_dfp_rdata); end
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_i_read();
        test_d_write();
        test_both_read();
        test_stray();
        test_rw_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
